// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I datapath: sequences fetch/decode/
// execute/memory/writeback, drives the shared memory handshake and all register strobes.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_load,
  input  logic        op_store,
  input  logic        reg_write,
  input  logic        jump,
  input  logic        jalr,
  input  logic        branch,
  input  logic        branch_taken,
  input  logic        illegal,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        opnd_we,
  output logic        alu_out_we,
  output logic        mdr_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [2:0]  state,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t             cur, nxt;
  logic [1:0]         cause_q, cause_d;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               timeout_hit;

  // The last permitted wait cycle; a ready in this same cycle still wins.
  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == WAIT_LAST);
  assign state       = cur;
  assign trap_cause  = cause_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    nxt          = cur;
    cause_d      = cause_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    opnd_we      = 1'b0;
    alu_out_we   = 1'b0;
    mdr_we       = 1'b0;
    rf_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'b00;
    trap         = 1'b0;

    unique case (cur)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we = 1'b1;
          nxt   = S_DECODE;
        end else if (timeout_hit) begin
          nxt     = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_DECODE: begin
        opnd_we = 1'b1;
        if (illegal || (op_load && op_store) || (jump && branch)) begin
          nxt     = S_TRAP;
          cause_d = 2'b01;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_out_we = 1'b1;
        if (branch) begin
          pc_we  = 1'b1;
          pc_sel = {1'b0, branch_taken};
          nxt    = S_FETCH;
        end else if (op_load || op_store) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = op_store;
        if (mem_ready) begin
          if (op_store) begin
            pc_we = 1'b1;
            nxt   = S_FETCH;
          end else begin
            mdr_we = 1'b1;
            nxt    = S_WB;
          end
        end else if (timeout_hit) begin
          nxt     = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_WB: begin
        rf_we  = reg_write;
        pc_we  = 1'b1;
        pc_sel = jalr ? 2'b10 : (jump ? 2'b01 : 2'b00);
        nxt    = S_FETCH;
      end
      default: begin
        trap = 1'b1;
      end
    endcase

    // Reset abandons any outstanding request immediately, not one cycle later.
    if (reset) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      opnd_we      = 1'b0;
      alu_out_we   = 1'b0;
      mdr_we       = 1'b0;
      rf_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = 2'b00;
      trap         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    if (reset) begin
      cur         <= S_FETCH;
      cause_q     <= 2'b00;
      wait_cnt    <= '0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cur     <= nxt;
      cause_q <= cause_d;
      if (mem_req && !mem_ready && (nxt == cur))
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if (cur != S_TRAP)
        cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_we)
        instret_cnt <= instret_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected outputs are queued as
// stimulus is driven and compared on the falling edge.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_load, op_store, reg_write, jump, jalr, branch, branch_taken, illegal;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, opnd_we, alu_out_we, mdr_we, rf_we, pc_we;
  logic [1:0]  pc_sel;
  logic [2:0]  state;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] cycle_cnt, instret_cnt;

  multicycle_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .op_load(op_load), .op_store(op_store), .reg_write(reg_write), .jump(jump),
    .jalr(jalr), .branch(branch), .branch_taken(branch_taken), .illegal(illegal),
    .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
    .opnd_we(opnd_we), .alu_out_we(alu_out_we), .mdr_we(mdr_we), .rf_we(rf_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .state(state), .trap(trap), .trap_cause(trap_cause),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  typedef enum {K_ADD, K_LW, K_SW, K_BEQ, K_JAL, K_JALR, K_ILL} kind_t;

  typedef struct packed {
    logic [2:0] st;
    logic [8:0] strb;
    logic [1:0] sel;
    logic       trap;
    logic [1:0] cause;
  } exp_t;

  // Strobe vector bit positions: {req, we, addr_sel, ir, opnd, alu, mdr, rf, pc}
  localparam logic [8:0] REQ  = 9'h100, WE  = 9'h080, ASEL = 9'h040, IR = 9'h020,
                         OPND = 9'h010, ALU = 9'h008, MDR  = 9'h004, RF = 9'h002, PC = 9'h001;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         exp_cycles = 0;
  int         exp_ret    = 0;
  logic [8:0] strb_obs;

  assign strb_obs = {mem_req, mem_we, mem_addr_sel, ir_we, opnd_we, alu_out_we, mdr_we, rf_we, pc_we};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] st, input logic [8:0] strb,
                              input logic [1:0] sel, input logic tr, input logic [1:0] cause);
    exp_t e;
    e.st = st; e.strb = strb; e.sel = sel; e.trap = tr; e.cause = cause;
    return e;
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      check("state", 32'(state), 32'(x.st));
      check("strobes", 32'(strb_obs), 32'(x.strb));
      check("pc_sel", 32'(pc_sel), 32'(x.sel));
      check("trap", 32'({trap, trap_cause}), 32'({x.trap, x.cause}));
    end
  end

  task automatic step(input logic rdy, input exp_t e);
    mem_ready = rdy;
    sb.push_back(e);
    if (e.st != 3'd7) exp_cycles++;
    if (e.strb[0]) exp_ret++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input kind_t k);
    op_load      = (k == K_LW);
    op_store     = (k == K_SW);
    reg_write    = (k inside {K_ADD, K_LW, K_JAL, K_JALR});
    jump         = (k inside {K_JAL, K_JALR});
    jalr         = (k == K_JALR);
    branch       = (k == K_BEQ);
    illegal      = (k == K_ILL);
    branch_taken = 1'($urandom_range(0, 1));
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_cycle_cnt"}, cycle_cnt, 32'(exp_cycles));
    check({tag, "_instret"}, instret_cnt, 32'(exp_ret));
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    check("rst_strobes", 32'({strb_obs, trap}), 32'd0);
    @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_cause", 32'(trap_cause), 32'd0);
    exp_cycles = 0;
    exp_ret    = 0;
    check_counters("rst");
    reset = 1'b0;
  endtask

  // Runs one instruction with fw FETCH wait cycles and mw MEM wait cycles.
  task automatic run_instr(input kind_t k, input int fw, input int mw, input logic taken);
    set_dec(k);
    if (k == K_BEQ) branch_taken = taken;
    for (int i = 0; i < fw; i++) step(1'b0, mk(3'd0, REQ, 2'b00, 1'b0, 2'b00));
    step(1'b1, mk(3'd0, REQ | IR, 2'b00, 1'b0, 2'b00));
    step(1'($urandom_range(0, 1)), mk(3'd1, OPND, 2'b00, 1'b0, 2'b00));
    if (k == K_ILL) begin
      step(1'b0, mk(3'd7, 9'h000, 2'b00, 1'b1, 2'b01));
      step(1'b1, mk(3'd7, 9'h000, 2'b00, 1'b1, 2'b01));
    end else if (k == K_BEQ) begin
      step(1'($urandom_range(0, 1)), mk(3'd2, ALU | PC, {1'b0, taken}, 1'b0, 2'b00));
    end else begin
      step(1'($urandom_range(0, 1)), mk(3'd2, ALU, 2'b00, 1'b0, 2'b00));
      if (k == K_LW || k == K_SW) begin
        for (int i = 0; i < mw; i++)
          step(1'b0, mk(3'd3, REQ | ASEL | ((k == K_SW) ? WE : 9'h000), 2'b00, 1'b0, 2'b00));
        if (k == K_SW) step(1'b1, mk(3'd3, REQ | WE | ASEL | PC, 2'b00, 1'b0, 2'b00));
        else           step(1'b1, mk(3'd3, REQ | ASEL | MDR, 2'b00, 1'b0, 2'b00));
      end
      if (k != K_SW)
        step(1'($urandom_range(0, 1)),
             mk(3'd4, PC | ((k == K_SW || k == K_BEQ) ? 9'h000 : RF),
                (k == K_JALR) ? 2'b10 : ((k == K_JAL) ? 2'b01 : 2'b00), 1'b0, 2'b00));
    end
    check_counters("instr");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    set_dec(K_ADD);
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    run_instr(K_ADD, 0, 0, 1'b0);
    check("add_cycles", cycle_cnt, 32'd4);
    check("add_instret", instret_cnt, 32'd1);
    run_instr(K_LW, 2, 2, 1'b0);
    check("lw_cycles", cycle_cnt, 32'd13);
    run_instr(K_SW, 0, 0, 1'b0);
    run_instr(K_BEQ, 0, 0, 1'b1);
    run_instr(K_BEQ, 0, 0, 1'b0);
    check("beq_cycles", cycle_cnt, 32'd23);
    run_instr(K_JAL, 1, 0, 1'b0);
    run_instr(K_JALR, 0, 0, 1'b0);
    run_instr(K_ILL, 0, 0, 1'b0);
    check("ill_frozen", cycle_cnt, 32'(exp_cycles));
    do_reset();

    for (int n = 0; n < 8; n++)
      run_instr(kind_t'($urandom_range(0, 5)), $urandom_range(0, 2), $urandom_range(0, 2),
                1'($urandom_range(0, 1)));

    // Reset while a load request is outstanding in MEM.
    set_dec(K_LW);
    step(1'b1, mk(3'd0, REQ | IR, 2'b00, 1'b0, 2'b00));
    step(1'b0, mk(3'd1, OPND, 2'b00, 1'b0, 2'b00));
    step(1'b0, mk(3'd2, ALU, 2'b00, 1'b0, 2'b00));
    step(1'b0, mk(3'd3, REQ | ASEL, 2'b00, 1'b0, 2'b00));
    do_reset();

    // Fetch that never completes: four request cycles, then bus-timeout trap.
    for (int i = 0; i < 4; i++) step(1'b0, mk(3'd0, REQ, 2'b00, 1'b0, 2'b00));
    step(1'b0, mk(3'd7, 9'h000, 2'b00, 1'b1, 2'b10));
    step(1'b1, mk(3'd7, 9'h000, 2'b00, 1'b1, 2'b10));
    check_counters("timeout");
    do_reset();

    // Ready arrives on the last allowed wait cycle: no trap.
    run_instr(K_ADD, 3, 0, 1'b0);

    @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
